// File: rtl/digit_to_seven_segment_display.sv
// rtl/digit_to_seven_segment_display.sv - serial command receiver, number recorder and two-digit seven-segment driver
`timescale 1ns/1ps
module digit_to_seven_segment_display #(
  parameter int DEPTH = 8,
  parameter int DWELL = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        rx_busy,
  output logic [13:0] Seven_Segment_Display
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [13:0] DISP_OFF  = 14'h3FFF;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, RECORD, DONE} cmd_state_t;

  rx_state_t   rx_state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        byte_valid;

  cmd_state_t  cmd_state;
  logic [5:0]  buf_mem [DEPTH];
  logic [NW-1:0] buf_cnt;
  logic [IW-1:0] show_idx;
  logic [CW-1:0] dwell_cnt;

  logic [5:0]  id;
  logic [5:0]  show_val;
  logic [3:0]  tens_d;
  logic [3:0]  units_d;
  logic [13:0] disp_next;

  assign id = data[5:0];

  // Active-low segment pattern for one decimal digit, ordered {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Serial receiver: two low start samples, eight data bits MSB first, one stop sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      data       <= 8'd0;
      rx_busy    <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx) begin
            rx_state <= RX_START;
            rx_busy  <= 1'b1;
          end
        end
        RX_START: begin
          if (!rx) begin
            rx_state <= RX_DATA;
            bit_cnt  <= 3'd0;
          end else begin
            rx_state <= RX_IDLE;
            rx_busy  <= 1'b0;
          end
        end
        RX_DATA: begin
          shreg   <= {shreg[6:0], rx};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_state <= RX_STOP;
        end
        RX_STOP: begin
          if (rx) begin
            data       <= shreg;
            byte_valid <= 1'b1;
          end
          rx_busy  <= 1'b0;
          rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Command FSM, number buffer and the DONE-mode dwell/index sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_state <= IDLE;
      buf_cnt   <= '0;
      show_idx  <= '0;
      dwell_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= 6'd0;
    end else begin
      if (cmd_state == DONE && buf_cnt != '0) begin
        if (dwell_cnt == CW'(DWELL - 1)) begin
          dwell_cnt <= '0;
          if (NW'(show_idx) + NW'(1) >= buf_cnt) show_idx <= '0;
          else                                   show_idx <= show_idx + IW'(1);
        end else begin
          dwell_cnt <= dwell_cnt + CW'(1);
        end
      end
      if (byte_valid) begin
        case (cmd_state)
          IDLE: begin
            if (id == 6'd5) begin
              cmd_state <= RECORD;
              buf_cnt   <= '0;
            end
          end
          RECORD: begin
            if (id == 6'd46) begin
              cmd_state <= DONE;
              show_idx  <= '0;
              dwell_cnt <= '0;
            end else if (id == 6'd0) begin
              cmd_state <= IDLE;
              buf_cnt   <= '0;
            end else if (id != 6'd5 && id < 6'd46 && buf_cnt < NW'(DEPTH)) begin
              buf_mem[IW'(buf_cnt)] <= id;
              buf_cnt               <= buf_cnt + NW'(1);
            end
          end
          DONE: begin
            if (id == 6'd47) begin
              cmd_state <= RECORD;
            end else if (id == 6'd5) begin
              cmd_state <= RECORD;
              buf_cnt   <= '0;
            end else if (id == 6'd0) begin
              cmd_state <= IDLE;
              buf_cnt   <= '0;
            end
          end
          default: cmd_state <= IDLE;
        endcase
      end
    end
  end

  // Select the number to show and encode it as two decimal digits
  always_comb begin
    show_val  = 6'd0;
    disp_next = DISP_OFF;
    if (cmd_state == RECORD) show_val = buf_mem[IW'(buf_cnt - NW'(1))];
    else                     show_val = buf_mem[show_idx];
    tens_d  = 4'(show_val / 6'd10);
    units_d = 4'(show_val % 6'd10);
    if (cmd_state != IDLE) begin
      if (buf_cnt == '0) disp_next = {SEG_DASH, SEG_DASH};
      else disp_next = {(tens_d == 4'd0) ? SEG_BLANK : seg7(tens_d), seg7(units_d)};
    end
  end

  // Registered display output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) Seven_Segment_Display <= DISP_OFF;
    else        Seven_Segment_Display <= disp_next;
  end

endmodule

// File: tb/tb_digit_to_seven_segment_display.sv
// tb/tb_digit_to_seven_segment_display.sv - scoreboard bench for the serial command display
`timescale 1ns/1ps
module tb_digit_to_seven_segment_display;

  localparam int DEPTH = 8;
  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [7:0]  data;
  logic        rx_busy;
  logic [13:0] ssd;

  digit_to_seven_segment_display #(.DEPTH(DEPTH), .DWELL(DWELL)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .rx                    (rx),
    .data                  (data),
    .rx_busy               (rx_busy),
    .Seven_Segment_Display (ssd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  typedef struct packed {
    int              cyc;
    int              st;
    int              dstart;
    int              cnt;
    logic [7:0][5:0] vals;
  } snap_t;

  typedef struct packed {
    int         cyc;
    logic [7:0] dat;
  } fall_t;

  snap_t snap_q[$];
  fall_t fall_q[$];

  // reference model: 0 idle, 1 record, 2 done
  int         m_st = 0;
  int         m_dstart = 0;
  int         m_buf[$];
  logic [7:0] m_data = 8'd0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
  endtask

  function automatic logic [13:0] dec_code(input int v);
    int t, u;
    t = v / 10;
    u = v % 10;
    return {(t == 0) ? 7'b1111111 : seg_tab[t], seg_tab[u]};
  endfunction

  function automatic logic [13:0] exp_disp(input snap_t s, input int c);
    if (s.st == 0) return 14'h3FFF;
    if (s.cnt == 0) return {7'b0111111, 7'b0111111};
    if (s.st == 1) return dec_code(int'(s.vals[s.cnt-1]));
    return dec_code(int'(s.vals[((c - s.dstart) / DWELL) % s.cnt]));
  endfunction

  function automatic snap_t cur_snap(input int c);
    snap_t s;
    s.cyc = c; s.st = m_st; s.dstart = m_dstart; s.cnt = m_buf.size(); s.vals = '0;
    foreach (m_buf[i]) s.vals[i] = 6'(m_buf[i]);
    return s;
  endfunction

  task automatic model_step(input int id, input int at);
    case (m_st)
      0: if (id == 5) begin m_st = 1; m_buf.delete(); end
      1: begin
        if (id == 46) begin m_st = 2; m_dstart = at; end
        else if (id == 0) begin m_st = 0; m_buf.delete(); end
        else if (id != 5 && id < 47 && m_buf.size() < DEPTH) m_buf.push_back(id);
      end
      default: begin
        if (id == 47) m_st = 1;
        else if (id == 5) begin m_st = 1; m_buf.delete(); end
        else if (id == 0) begin m_st = 0; m_buf.delete(); end
      end
    endcase
    snap_q.push_back(cur_snap(at));
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(stop_ok);
    if (stop_ok) begin
      m_data = b;
      model_step(int'(b[5:0]), cyc + 2);
    end
    fall_q.push_back('{cyc, m_data});
    send_bit(1'b1);
  endtask

  task automatic glitch();
    send_bit(1'b0);
    send_bit(1'b1);
    fall_q.push_back('{cyc, m_data});
    send_bit(1'b1);
  endtask

  // monitor: display every cycle against the model, data on every end of a frame
  initial begin : monitor
    snap_t cur;
    fall_t f;
    bit    have;
    logic  prev_busy;
    have = 1'b0;
    prev_busy = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        cur = snap_q.pop_front();
        have = 1'b1;
      end
      if (have) chk("display", 32'(ssd), 32'(exp_disp(cur, cyc)));
      if (!reset) begin
        chk("reset_busy", 32'(rx_busy), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
      end
      if (prev_busy && !rx_busy) begin
        if (fall_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame_end: rx_busy fell at cycle %0d, none expected", cyc);
        end else begin
          f = fall_q.pop_front();
          chk("frame_end_cycle", 32'(cyc), 32'(f.cyc));
          chk("data", 32'(data), 32'(f.dat));
        end
      end
      prev_busy = rx_busy;
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    int         r;
    int         pick;
    logic [7:0] b;
    reset = 1'b0;
    rx    = 1'b1;
    snap_q.push_back(cur_snap(0));
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(3);

    send_frame(8'd0, 1'b1);
    send_frame(8'd5, 1'b1);
    send_frame(8'd13, 1'b1);
    send_frame(8'd35, 1'b1);
    send_frame(8'd44, 1'b1);
    send_frame(8'd46, 1'b1);
    idle(30);
    send_frame(8'd47, 1'b1);
    send_frame(8'd30, 1'b1);
    send_frame(8'd38, 1'b1);
    send_frame(8'd46, 1'b1);
    idle(45);
    send_frame(8'd0, 1'b1);
    idle(3);

    send_frame(8'd5, 1'b1);
    send_frame(8'hC7, 1'b1);
    send_frame(8'd9, 1'b0);
    glitch();
    glitch();
    idle(4);
    for (int i = 0; i < 10; i++) send_frame(8'(10 + i), 1'b1);
    send_frame(8'd63, 1'b1);
    send_frame(8'd46, 1'b1);
    idle(40);
    send_frame(8'd5, 1'b1);
    send_frame(8'd46, 1'b1);
    idle(5);
    send_frame(8'd0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) glitch();
      else if (r < 16) send_frame(8'($urandom), 1'b0);
      else if (r < 26) idle($urandom_range(1, 15));
      else begin
        b = 8'($urandom);
        pick = $urandom_range(0, 9);
        case (pick)
          0: b[5:0] = 6'd5;
          1: b[5:0] = 6'd46;
          2: b[5:0] = 6'd47;
          3: b[5:0] = 6'd0;
          default: b[5:0] = 6'($urandom_range(1, 45));
        endcase
        send_frame(b, 1'b1);
      end
    end

    send_frame(8'd5, 1'b1);
    send_frame(8'd12, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b0;
    m_st = 0;
    m_buf.delete();
    m_data = 8'd0;
    fall_q.push_back('{cyc, 8'd0});
    snap_q.push_back(cur_snap(cyc));
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    send_frame(8'd5, 1'b1);
    send_frame(8'd21, 1'b1);
    idle(5);

    chk("pending_frames", 32'(fall_q.size()), 32'd0);
    chk("pending_snapshots", 32'(snap_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
